// File: rtl/display7seg_scan.sv
// Time-multiplexed driver for N common-anode 7-segment digits with shadowed inputs.
// Optional leading-zero suppression is built when DISPLAY7SEG_SCAN_LZS_EN is defined.
`timescale 1ns/1ps

module display7seg_scan #(
    parameter int N_DIGITS = 4,
    parameter int PRESCALE = 50000,
    parameter int CW       = 16
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  load,
    input  logic [4*N_DIGITS-1:0] dado,
    input  logic [N_DIGITS-1:0]   dp,
    input  logic [N_DIGITS-1:0]   blank,
    output logic [7:0]            leds,
    output logic [N_DIGITS-1:0]   an,
    output logic                  dbg_scan_o
);

    localparam int IW = (N_DIGITS > 1) ? $clog2(N_DIGITS) : 1;

    typedef enum logic {
        ST_GAP  = 1'b0,
        ST_SCAN = 1'b1
    } state_t;

    state_t              state_q, state_d;
    logic [IW-1:0]       idx_q, idx_d;
    logic [CW-1:0]       cnt_q, cnt_d;
    logic                tick;

    logic [4*N_DIGITS-1:0] dado_q;
    logic [N_DIGITS-1:0]   dp_q;
    logic [N_DIGITS-1:0]   blank_q;

    logic [7:0]            leds_q, leds_d;
    logic [N_DIGITS-1:0]   an_q, an_d;

    logic [N_DIGITS-1:0]   dark_w;
    logic [3:0]            cur_nib;
    logic                  cur_dp;
    logic                  cur_dark;

    function automatic logic [6:0] seg7(input logic [3:0] nib);
        logic [6:0] s;
        s = 7'h7F;
        case (nib)
            4'h0: s = 7'h40;
            4'h1: s = 7'h79;
            4'h2: s = 7'h24;
            4'h3: s = 7'h30;
            4'h4: s = 7'h19;
            4'h5: s = 7'h12;
            4'h6: s = 7'h02;
            4'h7: s = 7'h78;
            4'h8: s = 7'h00;
            4'h9: s = 7'h10;
            4'hA: s = 7'h08;
            4'hB: s = 7'h03;
            4'hC: s = 7'h46;
            4'hD: s = 7'h21;
            4'hE: s = 7'h06;
            4'hF: s = 7'h0E;
            default: s = 7'h7F;
        endcase
        return s;
    endfunction

    assign tick       = (state_q == ST_SCAN) && (cnt_q == CW'(PRESCALE - 1));
    assign dbg_scan_o = (state_q == ST_SCAN);
    assign leds       = leds_q;
    assign an         = an_q;

    // Per-digit darkness: explicit blank mask, optionally ORed with leading-zero suppression.
    always_comb begin
        dark_w = blank_q;
`ifdef DISPLAY7SEG_SCAN_LZS_EN
        begin
            logic zero_run;
            zero_run = 1'b1;
            for (int i = N_DIGITS - 1; i > 0; i--) begin
                zero_run = zero_run & (dado_q[4*i +: 4] == 4'h0);
                if (zero_run && !dp_q[i]) begin
                    dark_w[i] = 1'b1;
                end
            end
        end
`endif
    end

    always_comb begin
        cur_nib  = 4'h0;
        cur_dp   = 1'b0;
        cur_dark = 1'b1;
        for (int i = 0; i < N_DIGITS; i++) begin
            if (idx_q == IW'(i)) begin
                cur_nib  = dado_q[4*i +: 4];
                cur_dp   = dp_q[i];
                cur_dark = dark_w[i];
            end
        end
    end

    // The index advances on the SCAN->GAP transition so that the GAP following
    // reset leaves idx at 0 and the first lit digit is digit 0.
    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        cnt_d   = cnt_q;
        case (state_q)
            ST_SCAN: begin
                if (tick) begin
                    state_d = ST_GAP;
                    cnt_d   = '0;
                    idx_d   = (idx_q == IW'(N_DIGITS - 1)) ? '0 : idx_q + IW'(1);
                end else begin
                    cnt_d = cnt_q + CW'(1);
                end
            end
            ST_GAP: begin
                state_d = ST_SCAN;
                cnt_d   = '0;
            end
            default: begin
                state_d = ST_GAP;
                cnt_d   = '0;
            end
        endcase
    end

    always_comb begin
        leds_d = 8'hFF;
        an_d   = '1;
        if ((state_q == ST_SCAN) && !cur_dark) begin
            leds_d = {~cur_dp, seg7(cur_nib)};
            for (int i = 0; i < N_DIGITS; i++) begin
                an_d[i] = (idx_q != IW'(i));
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_GAP;
            idx_q   <= '0;
            cnt_q   <= '0;
            leds_q  <= 8'hFF;
            an_q    <= '1;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            cnt_q   <= cnt_d;
            leds_q  <= leds_d;
            an_q    <= an_d;
        end
    end

    // Shadow registers start blanked so the display stays dark until the first load.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            dado_q  <= '0;
            dp_q    <= '0;
            blank_q <= '1;
        end else if (load) begin
            dado_q  <= dado;
            dp_q    <= dp;
            blank_q <= blank;
        end
    end

endmodule

// File: tb/tb_display7seg_scan.sv
// Scoreboard bench for display7seg_scan: a 4-digit/PRESCALE=4 instance and a 1-digit/PRESCALE=2 instance.
`timescale 1ns/1ps

module tb_display7seg_scan;

  localparam int N4 = 4;
  localparam int P4 = 4;
  localparam int N1 = 1;
  localparam int P1 = 2;
  localparam int NEVER = 32'h3FFF_FFFF;

  // clock / reset
  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst4_n, rst1_n;
  logic        load4, load1;
  logic [15:0] dado4;
  logic [3:0]  dp4, blank4;
  logic [3:0]  dado1;
  logic        dp1, blank1;
  logic [7:0]  leds4, leds1;
  logic [3:0]  an4;
  logic        an1;
  logic        dbg4, dbg1;

  display7seg_scan #(.N_DIGITS(N4), .PRESCALE(P4), .CW(16)) dut4 (
    .clk(clk), .rst_n(rst4_n), .load(load4), .dado(dado4), .dp(dp4), .blank(blank4),
    .leds(leds4), .an(an4), .dbg_scan_o(dbg4)
  );

  display7seg_scan #(.N_DIGITS(N1), .PRESCALE(P1), .CW(4)) dut1 (
    .clk(clk), .rst_n(rst1_n), .load(load1), .dado(dado1), .dp(dp1), .blank(blank1),
    .leds(leds1), .an(an1), .dbg_scan_o(dbg1)
  );

  int edge_cnt = 0;
  always @(posedge clk) edge_cnt++;

  int n_cmp = 0;
  int n_err = 0;

  // scoreboard queues: {edge[31:0], an, leds}
  logic [43:0] exp4_q[$];
  logic [40:0] exp1_q[$];

  // expected display tables, packed {d3,d2,d1,d0}; 8'hFF means dark
  int          t0_4, t0_1;
  logic [31:0] tab4, tab4_new;
  logic [7:0]  tab1, tab1_new;
  logic        ld4_pending, ld1_pending;

  // Time-based expectation: from edge t0 on, each digit shows for p edges then one dark edge.
  function automatic logic [11:0] model(input int e, input int t0, input logic [31:0] tab,
                                        input int n, input int p);
    int t, q, d, ph;
    logic [3:0] a;
    logic [7:0] l;
    a = 4'hF;
    l = 8'hFF;
    t = e - t0;
    if (t >= 0) begin
      q  = t % (n * (p + 1));
      d  = q / (p + 1);
      ph = q % (p + 1);
      if (ph < p && tab[8*d +: 8] != 8'hFF) begin
        a = ~(4'(1) << d);
        l = tab[8*d +: 8];
      end
    end
    return {a, l};
  endfunction

  // driver tasks
  task automatic step();
    logic [11:0] m4, m1;
    @(posedge clk);
    #1;
    m4 = model(edge_cnt, t0_4, tab4, N4, P4);
    m1 = model(edge_cnt, t0_1, {24'hFFFFFF, tab1}, N1, P1);
    exp4_q.push_back({edge_cnt[31:0], m4});
    exp1_q.push_back({edge_cnt[31:0], m1[8], m1[7:0]});
    if (ld4_pending) begin
      tab4 = tab4_new;
      ld4_pending = 1'b0;
      load4 = 1'b0;
    end
    if (ld1_pending) begin
      tab1 = tab1_new;
      ld1_pending = 1'b0;
      load1 = 1'b0;
    end
  endtask

  task automatic set4(input logic [15:0] d, input logic [3:0] p, input logic [3:0] b,
                      input logic [31:0] tab);
    dado4 = d;
    dp4 = p;
    blank4 = b;
    load4 = 1'b1;
    tab4_new = tab;
    ld4_pending = 1'b1;
  endtask

  task automatic set1(input logic [3:0] d, input logic p, input logic b, input logic [7:0] tab);
    dado1 = d;
    dp1 = p;
    blank1 = b;
    load1 = 1'b1;
    tab1_new = tab;
    ld1_pending = 1'b1;
  endtask

  // monitor: pops and compares each edge's expectation at the following falling edge
  logic [43:0] e4;
  logic [40:0] e1;
  always @(negedge clk) begin
    while (exp4_q.size() > 0 && int'(exp4_q[0][43:12]) <= edge_cnt) begin
      e4 = exp4_q.pop_front();
      n_cmp++;
      if ({an4, leds4} !== e4[11:0]) begin
        n_err++;
        $display("FAIL dut4 edge %0d: an=%h leds=%h, expected an=%h leds=%h",
                 e4[43:12], an4, leds4, e4[11:8], e4[7:0]);
      end
    end
    while (exp1_q.size() > 0 && int'(exp1_q[0][40:9]) <= edge_cnt) begin
      e1 = exp1_q.pop_front();
      n_cmp++;
      if ({an1, leds1} !== e1[8:0]) begin
        n_err++;
        $display("FAIL dut1 edge %0d: an=%b leds=%h, expected an=%b leds=%h",
                 e1[40:9], an1, leds1, e1[8], e1[7:0]);
      end
    end
    n_cmp++;
    if ($countones(~an4) > 1) begin
      n_err++;
      $display("FAIL dut4 onehot edge %0d: an=%b, expected at most one low bit", edge_cnt, an4);
    end
  end

  // stimulus
  logic [31:0] lz_tab;
  initial begin
`ifdef DISPLAY7SEG_SCAN_LZS_EN
    lz_tab = 32'hFF40FFC0;
`else
    lz_tab = 32'hC040C0C0;
`endif
    t0_4 = NEVER;
    t0_1 = NEVER;
    tab4 = 32'hFFFFFFFF;
    tab1 = 8'hFF;
    tab4_new = tab4;
    tab1_new = tab1;
    ld4_pending = 1'b0;
    ld1_pending = 1'b0;
    rst4_n = 1'b0;
    rst1_n = 1'b0;
    // load held high during reset must be ignored
    load4 = 1'b1;
    dado4 = 16'hFFFF;
    dp4 = 4'hF;
    blank4 = 4'h0;
    load1 = 1'b1;
    dado1 = 4'hF;
    dp1 = 1'b1;
    blank1 = 1'b0;
    step();
    step();
    rst4_n = 1'b1;
    rst1_n = 1'b1;
    load4 = 1'b0;
    load1 = 1'b0;
    t0_4 = edge_cnt + 2;
    t0_1 = edge_cnt + 2;
    repeat (40) step();

    // basic hex pattern on both instances
    set4(16'h12AF, 4'h0, 4'h0, 32'hF9A4888E);
    set1(4'h5, 1'b0, 1'b0, 8'h92);
    step();
    repeat (45) step();

    // zeros with one decimal point
    set4(16'h0000, 4'b0100, 4'h0, lz_tab);
    step();
    repeat (25) step();

    // blank mask and dp on digit 0
    set4(16'h9876, 4'b0001, 4'b1010, 32'hFF80FF02);
    step();
    repeat (25) step();

    // reload coinciding with the first lit edge of digit 0
    set4(16'h4563, 4'h0, 4'h0, 32'h999282B0);
    step();
    repeat (22) step();
    while (((edge_cnt + 1 - t0_4) % (N4 * (P4 + 1))) != 0) step();
    set4(16'h4568, 4'h0, 4'h0, 32'h99928280);
    step();
    repeat (10) step();

    // asynchronous reset pulse while digit 2 is lit
    set4(16'h12AF, 4'h0, 4'h0, 32'hF9A4888E);
    step();
    repeat (20) step();
    while (((edge_cnt - t0_4) % (N4 * (P4 + 1))) != 11) step();
    @(negedge clk);
    #1;
    rst4_n = 1'b0;
    #0.5;
    n_cmp++;
    if ({an4, leds4} !== 12'hFFF) begin
      n_err++;
      $display("FAIL async_reset: an=%h leds=%h, expected an=F leds=FF", an4, leds4);
    end
    #0.5;
    rst4_n = 1'b1;
    t0_4 = edge_cnt + 2;
    tab4 = 32'hFFFFFFFF;
    repeat (25) step();
    set4(16'h12AF, 4'h0, 4'h0, 32'hF9A4888E);
    step();
    repeat (25) step();

    @(negedge clk);
    #1;
    n_cmp++;
    if (exp4_q.size() != 0 || exp1_q.size() != 0) begin
      n_err++;
      $display("FAIL drain: left %0d/%0d entries, expected 0/0", exp4_q.size(), exp1_q.size());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  // watchdog
  initial begin
    #200000;
    n_err++;
    $display("FAIL watchdog: time limit reached, expected run to end earlier");
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/display7seg_scan.md
Name: display7seg_scan

Overview:
- Time-multiplexed driver for N common-anode 7-segment digits. Successor to the single-digit hex decoder, parametrised in digit count.
- Captures a packed hex word, plus per-digit decimal-point and blank masks, into shadow registers on a load strobe.
- Scans digits one at a time at a prescaled refresh rate, with a one-clock anti-ghosting gap between digits.
- Sits between the processor's output register and the board display pins.

Parameters:
- N_DIGITS, 4, number of digits scanned (1..8).
- PRESCALE, 50000, clocks each digit is lit before advancing (min 2).
- CW, 16, prescaler counter width; must satisfy 2^CW >= PRESCALE.

Ports:
- clk  in  1  system clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- load  in  1  single-cycle strobe; captures dado, dp, blank into shadow registers.
- dado  in  4*N_DIGITS  packed hex nibbles; digit i = dado[4i+3:4i]; digit 0 is rightmost.
- dp  in  N_DIGITS  decimal point enable per digit, 1 = lit.
- blank  in  N_DIGITS  per-digit blank, 1 = digit dark.
- leds  out  8  segment bus {dp,g,f,e,d,c,b,a}, active-low.
- an  out  N_DIGITS  digit anode enables, active-low, one-hot-low or all-high.

Behaviour:
- Reset (async, rst_n=0):
  - Outputs: leds=8'hFF, an=all 1s.
  - Internal state: prescaler=0, digit index=0, state=GAP.
  - Shadow registers: dado=0, dp=0, blank=all 1s, so the display stays dark until the first load.
- Shadow capture:
  - load=1 at an edge copies dado/dp/blank into the shadow registers at that edge.
  - load is ignored while rst_n=0. Back-to-back loads are allowed; the last one wins.
- Prescaler:
  - Counts 0..PRESCALE-1 in SCAN state; tick asserts when the count is PRESCALE-1.
  - The counter clears on tick and is held at 0 in GAP.
- FSM, two states:
  - SCAN: an[idx]=0, all other anodes 1; leds = decode of shadow nibble idx, with leds[7] = ~shadow_dp[idx]. If shadow_blank[idx]=1, leds=8'hFF and an stays all 1s. On tick go to GAP.
  - GAP (exactly 1 clock): an=all 1s, leds=8'hFF. idx <= (idx==N_DIGITS-1) ? 0 : idx+1. Next state SCAN.
  - Each digit period is PRESCALE clocks lit plus 1 gap clock. Full frame = N_DIGITS*(PRESCALE+1) clocks.
- Output registering:
  - leds and an are registered and reflect the state and shadow contents of the previous edge.
  - A load at edge k affecting the currently lit digit appears on leds at edge k+1, mid-period, with no extra gap.
- Decode, active-low, segments a..g in bits 0..6 (hex, dp bit 1):
  - 0=C0, 1=F9, 2=A4, 3=B0, 4=99, 5=92, 6=82, 7=F8
  - 8=80, 9=90, A=88, B=83, C=C6, D=A1, E=86, F=8E
  - Bit 7 is then replaced by ~dp.
- N_DIGITS=1: idx stays 0; the GAP cycle is still inserted every PRESCALE clocks.
- Wrap-around: after digit N_DIGITS-1 the scan goes GAP, then digit 0. The index never takes values >= N_DIGITS.
- Reset asserted mid-scan: outputs go to their reset values immediately, without waiting for clk. After release, the first SCAN begins on the 2nd edge, at idx 0.
- an never has more than one bit low in any cycle.

Optional Feature:
- Macro: DISPLAY7SEG_SCAN_LZS_EN (leading-zero suppression).
- Defined:
  - A digit i>0 is treated as blanked when its shadow nibble and all higher-index nibbles are 0 and its shadow dp is 0. Digit 0 is never suppressed.
  - Suppression is evaluated from the shadow registers each SCAN cycle. It ORs with the blank mask.
- Undefined: all non-blanked digits are displayed, including leading zeros.

Test Plan:
- Reset then no load (PRESCALE=4, N_DIGITS=4) -> an=4'hF, leds=8'hFF for 40 clocks.
- load dado=16'h12AF, dp=0, blank=0 -> repeating sequence, each for 4 clocks separated by 1-clock gaps (an=F, leds=FF):
  - an=E, leds=8E
  - an=D, leds=88
  - an=B, leds=A4
  - an=7, leds=F9
- dp=4'b0100 with dado=16'h0000 -> digit 2 shows leds=40, the others C0. With LZS_EN: digits 3 is dark; digits 2 shows 40; digits 1 is dark; digit 0 shows C0.
- Load at the same edge a SCAN period is lit on digit 0, changing nibble 0 from 3 to 8 -> leds changes B0 to 80 on the next edge; an unchanged and no gap inserted.
- rst_n pulsed low for 1 ns mid-SCAN on digit 2 -> an=F, leds=FF immediately. After release the scan restarts at digit 0 and the shadow is blank (dark) until the next load.
- N_DIGITS=1, PRESCALE=2, load dado=4'h5 -> pattern an=0,0,1 / leds=92,92,FF repeating.
